// File: rtl/ccc_cfg_pkg.sv
// Shared definitions for the CCC APB configuration master.
//   CCC_ADDR_W / CCC_DATA_W : APB address / data widths of the CCC config port
//   CCC_LOCK_TIMEOUT_DEF    : default PLL lock wait bound, in clk cycles
//   ccc_cfg_state_t         : master FSM state encoding
package ccc_cfg_pkg;
  localparam int CCC_ADDR_W           = 6;
  localparam int CCC_DATA_W           = 8;
  localparam int CCC_LOCK_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    LOCK_WAIT
  } ccc_cfg_state_t;
endpackage

// File: rtl/ccc_lock_sync.sv
// Multi-flop synchronizer for the asynchronous CCC LOCK output.
//   clk, reset : clock and synchronous active-high reset (clears the chain)
//   d          : asynchronous input
//   q          : synchronized output, SYNC_STAGES cycles behind d
module ccc_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ccc_apb_cfg_master.sv
// Single-outstanding command front end that drives the CCC APB config port.
// A command is accepted in IDLE, run as one zero-wait APB transfer
// (SETUP, ACCESS), then answered with a one-cycle rsp_valid pulse.
// Build option: CCC_CFG_LOCK_WAIT_EN -- when defined, a commit write waits in
// LOCK_WAIT for the synchronized PLL lock (or LOCK_TIMEOUT cycles, which
// raises rsp_err) before responding.
//   cmd_*                 : command handshake and fields
//   rsp_valid/rdata/err   : response pulse, read data, lock-timeout flag
//   psel..pwdata, prdata  : APB initiator (clk doubles as PCLK, no PREADY)
//   pll_lock / lock_sync  : raw CCC LOCK input / its synchronized copy
module ccc_apb_cfg_master
  import ccc_cfg_pkg::*;
#(
  parameter int LOCK_TIMEOUT = CCC_LOCK_TIMEOUT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_commit,
  input  logic [CCC_ADDR_W-1:0] cmd_addr,
  input  logic [CCC_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [CCC_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [CCC_ADDR_W-1:0] paddr,
  output logic [CCC_DATA_W-1:0] pwdata,
  input  logic [CCC_DATA_W-1:0] prdata,
  input  logic                  pll_lock,
  output logic                  lock_sync
);
  ccc_cfg_state_t        state_q, state_d;
  logic                  write_q;
  logic [CCC_ADDR_W-1:0] addr_q;
  logic [CCC_DATA_W-1:0] wdata_q;
  logic [CCC_DATA_W-1:0] rdata_q;
  logic                  accept;

  assign accept = (state_q == IDLE) && cmd_valid;

  ccc_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_sync)
  );

`ifdef CCC_CFG_LOCK_WAIT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             commit_q;
  logic             err_q;
  logic             lock_seen;
  logic             tmo;

  // cnt_q is zero only in the first LOCK_WAIT cycle; lock_sync there may
  // still reflect the lock from before the reconfiguration, so skip it.
  assign lock_seen = lock_sync && (cnt_q != '0);
  assign tmo       = (cnt_q == CNT_W'(LOCK_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) commit_q <= cmd_commit;
      if (state_q == ACCESS) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (state_q == LOCK_WAIT) begin
        if (!tmo) cnt_q <= cnt_q + 1'b1;
        if (!lock_seen && tmo) err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = err_q;
`else
  logic unused_nolock;
  assign unused_nolock = cmd_commit ^ (LOCK_TIMEOUT == 0);
  assign rsp_err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (cmd_valid) state_d = SETUP;
      SETUP:  state_d = ACCESS;
`ifdef CCC_CFG_LOCK_WAIT_EN
      ACCESS: state_d = (write_q && commit_q) ? LOCK_WAIT : RESP;
      LOCK_WAIT: if (lock_seen || tmo) state_d = RESP;
`else
      ACCESS: state_d = RESP;
      LOCK_WAIT: state_d = IDLE;
`endif
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:   cmd_ready = 1'b1;
      SETUP:  begin psel = 1'b1; pwrite = write_q; end
      ACCESS: begin psel = 1'b1; penable = 1'b1; pwrite = write_q; end
      RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command capture and read data; paddr/pwdata keep the last command
  // between transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (state_q == ACCESS) rdata_q <= write_q ? '0 : prdata;
    end
  end

  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
`timescale 1ns/1ps
module tb_ccc_apb_cfg_master;
  localparam int SYNC = 2;
  localparam int LT_S = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0, cmd_commit = 1'b0;
  logic [5:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, lock_sync;
  logic [7:0] rsp_rdata, pwdata, prdata;
  logic [5:0] paddr;
  logic       pll_lock = 1'b1;

  int checks = 0, errors = 0, cyc = 0;
  int n_rsp = 0;
  bit mon_en = 1'b0;
  int lw_lat = 3;
  logic lw_err = 1'b0;
  logic [5:0] last_addr = '0;
  logic [7:0] last_wdata = '0;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [5:0] a);
    logic [7:0] v;
    v = {a[3:0], a[5:4], 2'b01} ^ 8'h3C;
    if (a == 6'h15) v = 8'hA7;
    return v;
  endfunction

  // CCC read data is only valid on the ACCESS cycle; junk elsewhere.
  assign prdata = (psel && penable) ? rom(paddr) : 8'hEE;

  ccc_apb_cfg_master #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_commit(cmd_commit), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pll_lock(pll_lock), .lock_sync(lock_sync)
  );

`ifdef CCC_CFG_LOCK_WAIT_EN
  logic       t_valid = 1'b0, t_write = 1'b0, t_commit = 1'b0;
  logic [5:0] t_addr = '0;
  logic [7:0] t_wdata = '0;
  logic       t_ready, t_rsp_valid, t_rsp_err, t_psel, t_penable, t_pwrite, t_lsync;
  logic [7:0] t_rdata, t_pwdata;
  logic [5:0] t_paddr;

  ccc_apb_cfg_master #(.LOCK_TIMEOUT(LT_S), .SYNC_STAGES(SYNC)) dut_to (
    .clk(clk), .reset(reset),
    .cmd_valid(t_valid), .cmd_ready(t_ready), .cmd_write(t_write),
    .cmd_commit(t_commit), .cmd_addr(t_addr), .cmd_wdata(t_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rdata), .rsp_err(t_rsp_err),
    .psel(t_psel), .penable(t_penable), .pwrite(t_pwrite), .paddr(t_paddr),
    .pwdata(t_pwdata), .prdata(8'h96), .pll_lock(1'b0), .lock_sync(t_lsync)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: the entry at the head of exp_q defines what APB
  // phase and response each cycle must show, counted from acceptance.
  always @(negedge clk) begin
    exp_t e;
    logic ep, en;
    int   ph;
    if (mon_en) begin
      chk("cmd_ready", cmd_ready, exp_q.size() == 0);
      ep = 1'b0; en = 1'b0; e.wr = 1'b0;
      if (exp_q.size() != 0) begin
        e  = exp_q[0];
        ph = cyc - e.acc;
        ep = (ph == 1) || (ph == 2);
        en = (ph == 2);
        chk("rsp_valid", rsp_valid, ph == e.lat);
        if (ph == e.lat) begin
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          n_rsp++;
        end
        if (ph >= e.lat) void'(exp_q.pop_front());
      end else begin
        chk("rsp_valid idle", rsp_valid, 0);
      end
      chk("psel", psel, ep);
      chk("penable", penable, en);
      chk("pwrite", pwrite, ep && e.wr);
      if (ep) begin
        chk("paddr", paddr, e.addr);
        chk("pwdata", pwdata, e.wdata);
      end else begin
        chk("paddr hold", paddr, last_addr);
        chk("pwdata hold", pwdata, last_wdata);
      end
      if (cmd_valid && cmd_ready) begin
        e.wr    = cmd_write;
        e.addr  = cmd_addr;
        e.wdata = cmd_wdata;
        e.rdata = cmd_write ? 8'h00 : rom(cmd_addr);
        e.acc   = cyc;
`ifdef CCC_CFG_LOCK_WAIT_EN
        e.lat = (cmd_write && cmd_commit) ? lw_lat : 3;
        e.err = (cmd_write && cmd_commit) ? lw_err : 1'b0;
`else
        e.lat = 3;
        e.err = 1'b0;
`endif
        exp_q.push_back(e);
        last_addr  = cmd_addr;
        last_wdata = cmd_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents a command and returns just after the accepting edge. Unless
  // hold is set, valid drops and the fields are scrambled so the DUT must
  // be working from its registered copy.
  task automatic send(input logic wr, input logic cm, input logic [5:0] a,
                      input logic [7:0] d, input bit hold);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_commit = cm; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_commit = 1'b0; cmd_addr = ~a; cmd_wdata = ~d;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("drain timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
  endtask

  task automatic chk_rst();
    chk("rst psel", psel, 0);       chk("rst penable", penable, 0);
    chk("rst pwrite", pwrite, 0);   chk("rst paddr", paddr, 0);
    chk("rst pwdata", pwdata, 0);   chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0); chk("rst rsp_err", rsp_err, 0);
    chk("rst lock_sync", lock_sync, 0); chk("rst cmd_ready", cmd_ready, 1);
  endtask

  task automatic do_reset(input int cycles);
    mon_en = 1'b0; cmd_valid = 1'b0; reset = 1'b1;
    repeat (cycles) begin @(posedge clk); @(negedge clk); chk_rst(); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    last_addr = '0; last_wdata = '0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready after reset", cmd_ready, 1);
    tick();
  endtask

`ifdef CCC_CFG_LOCK_WAIT_EN
  task automatic t_xact(input logic wr, input logic cm, output int lat,
                        output logic err, output logic [7:0] rd);
    int a, n;
    t_valid = 1'b1; t_write = wr; t_commit = cm; t_addr = 6'h07; t_wdata = 8'h3A;
    @(negedge clk);
    chk("t ready", t_ready, 1);
    a = cyc;
    @(posedge clk); #1;
    t_valid = 1'b0;
    n = 0; lat = -1; err = 1'b0; rd = 8'h00;
    while (n < 200) begin
      @(negedge clk); n++;
      if (t_rsp_valid) begin lat = cyc - a; err = t_rsp_err; rd = t_rdata; break; end
    end
    tick();
  endtask
`endif

  initial begin
    int r0;
`ifdef CCC_CFG_LOCK_WAIT_EN
    int lat;
    logic err;
    logic [7:0] rd;
`endif
    do_reset(2);
    repeat (SYNC + 1) tick();
    chk("lock_sync high", lock_sync, 1);

    // Read 0x15, CCC returns 0xA7
    send(1'b0, 1'b0, 6'h15, 8'h00, 1'b0);
    wait_idle(20);
    // Plain write
    send(1'b1, 1'b0, 6'h3F, 8'h5C, 1'b0);
    wait_idle(20);
    // Mixed traffic
    for (int i = 0; i < 6; i++) begin
      send(1'($urandom_range(0, 1)), 1'b0, 6'($urandom_range(0, 63)),
           8'($urandom_range(0, 255)), 1'b0);
      wait_idle(20);
    end

    // Commit write
`ifdef CCC_CFG_LOCK_WAIT_EN
    lw_lat = 100 + SYNC + 1; lw_err = 1'b0;
    send(1'b1, 1'b1, 6'h02, 8'h81, 1'b0);
    tick();
    pll_lock = 1'b0;              // drops during ACCESS: stale lock in first LOCK_WAIT cycle
    repeat (10) tick();
    chk("lock_sync low", lock_sync, 0);
    repeat (88) tick();
    pll_lock = 1'b1;              // 100 cycles after acceptance
    wait_idle(200);
`else
    send(1'b1, 1'b1, 6'h02, 8'h81, 1'b0);
    wait_idle(20);
`endif

    // Back-to-back with valid held high
    r0 = n_rsp;
    for (int i = 0; i < 5; i++)
      send(i[0], 1'b0, 6'(8 + i), 8'(8'h40 + i), 1'b1);
    cmd_valid = 1'b0;
    wait_idle(20);
    chk("b2b responses", n_rsp - r0, 5);

    // Reset during ACCESS
    send(1'b0, 1'b0, 6'h21, 8'h00, 1'b0);
    tick();
    do_reset(2);
    repeat (4) tick();

`ifdef CCC_CFG_LOCK_WAIT_EN
    // Reset during LOCK_WAIT
    pll_lock = 1'b0;
    lw_lat = 9999;
    send(1'b1, 1'b1, 6'h33, 8'h11, 1'b0);
    repeat (6) tick();
    do_reset(2);
    pll_lock = 1'b1;
    repeat (4) tick();

    // Timeout on the short-timeout instance, then a read clears rsp_err
    t_xact(1'b1, 1'b1, lat, err, rd);
    chk("t timeout latency", lat, LT_S + 4);
    chk("t timeout err", err, 1);
    chk("t timeout rdata", rd, 8'h00);
    t_xact(1'b0, 1'b0, lat, err, rd);
    chk("t read latency", lat, 3);
    chk("t read err", err, 0);
    chk("t read rdata", rd, 8'h96);
    chk("t idle psel", t_psel, 0);
    chk("t idle penable", t_penable, 0);
    chk("t idle pwrite", t_pwrite, 0);
    chk("t paddr hold", t_paddr, 6'h07);
    chk("t pwdata hold", t_pwdata, 8'h3A);
    chk("t lock_sync", t_lsync, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/ccc_apb_cfg_master.md
CCC_APB_CFG_MASTER -- requirements
Module: ccc_apb_cfg_master

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 4096, meaning the maximum number of cycles to wait for PLL lock after a commit write.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the lock input synchronizer (range 2..3).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, which is also driven to the CCC as its APB PCLK.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-007 SHALL have ports cmd_write (input, 1 bit), cmd_commit (input, 1 bit), cmd_addr (input, 6 bits) and cmd_wdata (input, 8 bits): command fields.
REQ-008 SHALL have ports rsp_valid (output, 1 bit; one-cycle pulse), rsp_rdata (output, 8 bits) and rsp_err (output, 1 bit; lock timeout).
REQ-009 SHALL have APB initiator ports psel, penable and pwrite (outputs, 1 bit each), paddr (output, 6 bits), pwdata (output, 8 bits) and prdata (input, 8 bits).
REQ-010 SHALL have port pll_lock, input, 1 bit, fed by the CCC LOCK output, which is asynchronous to clk.
REQ-011 SHALL have port lock_sync, output, 1 bit: the synchronized lock signal.

Function
REQ-012 SHALL implement the states IDLE, SETUP, ACCESS, RESP and LOCK_WAIT.
REQ-013 In IDLE, cmd_ready SHALL be 1; on cmd_valid&&cmd_ready the block SHALL register all command fields and go to SETUP.
REQ-014 cmd_ready SHALL be 0 in every state other than IDLE; at most one command SHALL be outstanding.
REQ-015 In SETUP, psel SHALL be 1 and penable 0, with paddr, pwrite and pwdata driven from the registered command; the next state SHALL be ACCESS.
REQ-016 In ACCESS, psel and penable SHALL both be 1 for exactly one cycle, with paddr, pwrite and pwdata held stable from SETUP; the CCC is zero-wait and has no PREADY.
REQ-017 On the ACCESS cycle of a read, rsp_rdata SHALL capture prdata.
REQ-018 For a write, rsp_rdata SHALL be 0x00.
REQ-019 After ACCESS, the next state SHALL be LOCK_WAIT for a write with commit=1 (only when CCC_CFG_LOCK_WAIT_EN is defined), otherwise RESP.
REQ-020 In RESP, rsp_valid SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-021 Command latency from acceptance to rsp_valid SHALL be 3 cycles when there is no lock wait.
REQ-022 psel, penable and pwrite SHALL be 0 in IDLE, RESP and LOCK_WAIT.
REQ-023 paddr and pwdata SHALL hold their last values outside APB transfers.
REQ-024 The timeout counter width SHALL be $clog2(LOCK_TIMEOUT+1).
REQ-025 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-026 On entry to LOCK_WAIT, the timeout counter SHALL be cleared.
REQ-027 In LOCK_WAIT, if lock_sync is 1 the block SHALL go to RESP with rsp_err=0.
REQ-028 In LOCK_WAIT, if the counter reaches LOCK_TIMEOUT with lock_sync still 0, the block SHALL go to RESP with rsp_err=1.
REQ-029 In LOCK_WAIT, lock and timeout SHALL be checked in that priority order, so that lock wins when both occur in the same cycle.
REQ-030 lock_sync SHALL be a SYNC_STAGES-deep flop chain on pll_lock.
REQ-031 lock_sync SHALL be ignored for its first sample after entry to LOCK_WAIT, so that a stale pre-reconfiguration lock is not accepted.
REQ-032 rsp_err SHALL be 0 for every non-commit command.
REQ-033 A cmd_valid asserted outside IDLE SHALL be neither consumed nor lost; the requester holds it until cmd_ready.

Reset
REQ-034 reset SHALL take effect at the next clk edge and SHALL override all other behaviour in that cycle.
REQ-035 In reset, the state SHALL be IDLE and psel, penable and pwrite SHALL be 0.
REQ-036 In reset, paddr SHALL be 0x00, pwdata SHALL be 0x00, rsp_valid SHALL be 0, rsp_rdata SHALL be 0x00, rsp_err SHALL be 0 and the counter SHALL be 0.
REQ-037 In reset, the synchronizer flops and lock_sync SHALL be 0.
REQ-038 A reset in SETUP, ACCESS or LOCK_WAIT SHALL abort the transfer with no rsp_valid.
REQ-039 cmd_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-040 The macro CCC_CFG_LOCK_WAIT_EN SHALL select whether the lock-wait feature is compiled in.
REQ-041 With CCC_CFG_LOCK_WAIT_EN defined, the LOCK_WAIT state, timeout counter and rsp_err path SHALL exist as specified above.
REQ-042 Without CCC_CFG_LOCK_WAIT_EN, cmd_commit SHALL be ignored, rsp_err SHALL be tied to 0 and every command SHALL complete in 3 cycles.
REQ-043 Without CCC_CFG_LOCK_WAIT_EN, the timeout counter SHALL be absent; the synchronizer and lock_sync SHALL remain present.

Structure
REQ-044 A shared package ccc_cfg_pkg SHALL hold CCC_ADDR_W=6, CCC_DATA_W=8, the state enum type ccc_cfg_state_t and the default LOCK_TIMEOUT constant.
REQ-045 The synchronizer SHALL be the sub-module ccc_lock_sync, parameterized by SYNC_STAGES, with ports clk, reset, d and q.
REQ-046 The FSM, the APB drive logic and the counter SHALL reside in the top module.

Verification
REQ-047 Bench SHALL apply a read with addr=0x15 and prdata=0xA7 in ACCESS, and SHALL check psel=1,penable=0 then psel=1,penable=1, rsp_valid 3 cycles after acceptance with rsp_rdata=0xA7 and rsp_err=0.
REQ-048 Bench SHALL apply a write with addr=0x3F, wdata=0x5C and commit=0, and SHALL check pwrite=1 and paddr/pwdata stable across SETUP and ACCESS, rsp_rdata=0x00, and cmd_ready low for 3 cycles.
REQ-049 With the macro defined, bench SHALL apply a commit write with pll_lock dropping, then rising 100 cycles after acceptance, and SHALL check rsp_valid about 100+SYNC_STAGES cycles later with rsp_err=0.
REQ-050 With the macro defined, LOCK_TIMEOUT=16 and pll_lock held at 0, bench SHALL apply a commit write and SHALL check rsp_err=1 at timeout with no counter wrap.
REQ-051 Bench SHALL assert reset during ACCESS and during LOCK_WAIT, and SHALL check all outputs at their reset values next cycle, no rsp_valid, and cmd_ready=1 after release.
REQ-052 Bench SHALL present back-to-back commands with cmd_valid held high, and SHALL check each one accepted only in IDLE with no command dropped or duplicated.
